// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the
// requester that did not own the previous access.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner
);

  // Pick the winner from the current request pattern.
  always_comb begin
    owner = REQ_CORE;
    if (req == 2'b10)      owner = REQ_DMA;
    else if (req == 2'b11) owner = ~last_owner;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the core (0) and the
// boot/debug DMA (1). One access in flight; all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req_i,
  input  logic [1:0]                  we_i,
  input  logic [1:0][ADDR_W-1:0]      addr_i,
  input  logic [1:0][DATA_W-1:0]      wdata_i,
  input  logic [1:0][DATA_W/8-1:0]    be_i,
  output logic [1:0]                  gnt_o,
  output logic [1:0]                  rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic                        busy_o
);

  arb_state_e       state;
  logic             last_owner;
  logic             owner;
  logic             pick;
  logic [LAT_W-1:0] wait_cnt;

  rr_arb2 u_rr (
    .req        (req_i),
    .last_owner (last_owner),
    .owner      (pick)
  );

  // Access sequencer: the mem_* registers double as the latched request,
  // so they naturally hold their values outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= REQ_DMA;
      owner       <= REQ_CORE;
      wait_cnt    <= '0;
      gnt_o       <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      busy_o      <= 1'b0;
    end else begin
      gnt_o    <= '0;
      rvalid_o <= '0;
      mem_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner        <= pick;
            mem_we_o     <= we_i[pick];
            mem_addr_o   <= addr_i[pick];
            mem_wdata_o  <= wdata_i[pick];
            mem_be_o     <= be_i[pick];
            mem_en_o     <= 1'b1;
            gnt_o[pick]  <= 1'b1;
            busy_o       <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= LAT_W'(MEM_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            // Writes return a zero data word alongside their ack.
            rvalid_o[owner] <= 1'b1;
            rdata_o         <= mem_we_o ? '0 : mem_rdata_i;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          last_owner <= owner;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers queue requests, a monitor predicts the winner,
// memory strobe and response from a plain behavioural memory model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A (MEM_LATENCY = 1): random + directed traffic
  logic [1:0]          req, we, gnt, rvalid;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic [1:0][BW-1:0]  be;
  logic [DW-1:0]       rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]       mem_addr;
  logic [BW-1:0]       mem_be;
  logic                mem_en, mem_we, busy;

  // DUT B (MEM_LATENCY = 4): directed latency / hold test
  logic [1:0]          req2, we2, gnt2, rvalid2;
  logic [1:0][AW-1:0]  addr2;
  logic [1:0][DW-1:0]  wdata2;
  logic [1:0][BW-1:0]  be2;
  logic [DW-1:0]       rdata2, mem_wdata2, mem_rdata2;
  logic [AW-1:0]       mem_addr2;
  logic [BW-1:0]       mem_be2;
  logic                mem_en2, mem_we2, busy2;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rdata_i(mem_rdata), .busy_o(busy));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .req_i(req2), .we_i(we2), .addr_i(addr2),
    .wdata_i(wdata2), .be_i(be2), .gnt_o(gnt2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .mem_en_o(mem_en2), .mem_we_o(mem_we2),
    .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2), .mem_be_o(mem_be2),
    .mem_rdata_i(mem_rdata2), .busy_o(busy2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct {
    logic [1:0]    own;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  req_t req_q[2][$];
  rsp_t rsp_q[$];
  logic gnt_log[$];

  logic [DW-1:0] env_mem [16];   // memory seen by the DUT
  logic [DW-1:0] ref_mem [16];   // expected memory contents
  logic [LAT:0]  rd_v;
  logic [DW-1:0] rd_d [0:LAT];

  int   cyc = 0;
  bit   seen = 0;
  logic [1:0] req_smp;
  logic rst_smp;

  initial begin
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = (32'h0101_0101 * i) ^ 32'hA5A5_5A5A;
      ref_mem[i] = (32'h0101_0101 * i) ^ 32'hA5A5_5A5A;
    end
    env_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    rd_v = '0;
    for (int i = 0; i <= LAT; i++) rd_d[i] = '0;
  end

  // What the arbiter saw on each edge.
  always @(posedge clk) begin
    cyc++;
    req_smp = req;
    rst_smp = reset;
    seen    = 1'b1;
  end

  // Memory macro for DUT A: fixed latency, garbage outside the valid slot.
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      rd_v[i] = rd_v[i-1];
      rd_d[i] = rd_d[i-1];
    end
    rd_v[0] = mem_en && !mem_we;
    rd_d[0] = env_mem[mem_addr[5:2]];
    if (mem_en && mem_we)
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    mem_rdata = rd_v[LAT] ? rd_d[LAT] : $urandom;
  end

  // Monitor / scoreboard for DUT A.
  logic          ref_last = 1'b1;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] prev_rdata = '0;

  always @(negedge clk) begin : mon
    logic [1:0] eg;
    logic       e;
    logic       bexp;
    req_t       r;
    rsp_t       s;
    if (seen) begin
      if (rst_smp) begin
        chk("rst_ctl", {58'd0, gnt, rvalid, mem_en, mem_we}, 64'd0);
        chk("rst_busy", busy, 0);
        chk("rst_data", {rdata, mem_wdata}, 64'd0);
        chk("rst_addr", {28'd0, mem_addr, mem_be}, 64'd0);
        rsp_q.delete();
        req_q[0].delete();
        req_q[1].delete();
        ref_last   = 1'b1;
        prev_rdata = '0;
      end else begin
        bexp = (gnt != 0) || (rsp_q.size() != 0);
        chk("busy", busy, bexp);
        chk("gnt_rvalid_excl", ((gnt != 0) && (rvalid != 0)) || gnt == 2'b11 || rvalid == 2'b11, 0);
        if (gnt != 0) begin
          chk("gnt_had_req", req_smp != 0, 1);
          e  = (req_smp == 2'b11) ? ~ref_last : req_smp[1];
          eg = 2'b01 << e;
          chk("gnt_owner", gnt, eg);
          chk("gnt_while_busy", rsp_q.size(), 0);
          chk("mem_en_at_gnt", mem_en, 1);
          gnt_log.push_back(e);
          ref_last = e;
          chk("gnt_pending", req_q[e].size() != 0, 1);
          if (req_q[e].size() != 0) begin
            r = req_q[e].pop_front();
            chk("mem_we", mem_we, r.we);
            chk("mem_addr", mem_addr, r.addr);
            chk("mem_wdata", mem_wdata, r.wdata);
            chk("mem_be", mem_be, r.be);
            cur_addr = r.addr;
            s.own = eg;
            s.due = cyc + LAT + 1;
            if (r.we) begin
              for (int b = 0; b < BW; b++)
                if (r.be[b]) ref_mem[r.addr[5:2]][8*b +: 8] = r.wdata[8*b +: 8];
              s.data = '0;
            end else begin
              s.data = ref_mem[r.addr[5:2]];
            end
            rsp_q.push_back(s);
          end
        end else begin
          chk("mem_en_idle", mem_en, 0);
          if (busy) chk("addr_hold", mem_addr, cur_addr);
        end
        if (rvalid != 0) begin
          chk("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            s = rsp_q.pop_front();
            chk("rvalid_owner", rvalid, s.own);
            chk("rdata", rdata, s.data);
            chk("rsp_cycle", cyc, s.due);
          end
        end else begin
          chk("rdata_hold", rdata, prev_rdata);
        end
        prev_rdata = rdata;
      end
    end
  end

  // Raise a request, hold it until granted, then drop it and scramble fields.
  task automatic issue(input int n, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_t r;
    int   to;
    r.we = w; r.addr = a; r.wdata = d; r.be = b;
    req_q[n].push_back(r);
    we[n] = w; addr[n] = a; wdata[n] = d; be[n] = b; req[n] = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end while (!gnt[n] && to < 200);
    chk("gnt_timeout", gnt[n], 1);
    req[n]   = 1'b0;
    addr[n]  = $urandom;
    wdata[n] = $urandom;
  endtask

  task automatic drive(input int n, input int cnt, input int gap);
    for (int k = 0; k < cnt; k++) begin
      if (k > 0 && gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      issue(n, 1'($urandom_range(0, 1)), 32'h100 | 32'($urandom_range(0, 15) << 2),
            $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic drain();
    int to;
    to = 0;
    while (rsp_q.size() != 0 && to < 100) begin @(negedge clk); to++; end
    chk("drain", rsp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; be2 = '0;
    mem_rdata2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single core read, then single DMA write.
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    drain();
    issue(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    drain();

    // Continuous tie: last owner was the DMA, so core goes first.
    gnt_log.delete();
    fork
      drive(0, 2, 0);
      drive(1, 2, 0);
    join
    drain();
    chk("tie_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      chk("tie_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b0101);

    // Random traffic from both requesters.
    fork
      drive(0, 40, 3);
      drive(1, 40, 3);
    join
    drain();

    // Reset in WAIT: the core read must never complete.
    issue(0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    gnt_log.delete();
    fork
      drive(0, 1, 0);
      drive(1, 1, 0);
    join
    drain();
    chk("post_reset_tie", {gnt_log.size() == 2, gnt_log[0], gnt_log[1]}, 3'b101);

    // DUT B: latency-4 read, core changes its address while the read waits.
    be2[0]    = 4'hF;
    wdata2[0] = 32'h5555_AAAA;
    addr2[0]  = 32'h0000_0020;
    req2      = 2'b01;
    mem_rdata2 = $urandom;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("l4_gnt", gnt2, (k == 1 || k == 8) ? 2'b01 : 2'b00);
      chk("l4_mem_en", mem_en2, (k == 1 || k == 8));
      chk("l4_busy", busy2, k != 7);
      chk("l4_rvalid", rvalid2, (k == 6) ? 2'b01 : 2'b00);
      chk("l4_rdata", rdata2, (k >= 6) ? 32'hCAFE_F00D : 32'h0);
      chk("l4_mem_addr", mem_addr2, (k >= 8) ? 32'h40 : 32'h20);
      if (k == 1) chk("l4_mem_ctl", {mem_we2, mem_be2, mem_wdata2}, {1'b0, 4'hF, 32'h5555_AAAA});
      if (k == 3) addr2[0] = 32'h0000_0040;
      if (k == 8) req2 = 2'b00;
      mem_rdata2 = (k == 5) ? 32'hCAFE_F00D : $urandom;
    end
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters.
- Requester 0 is the multi-cycle core's memory access path (fetch and load/store). Requester 1 is the boot loader / debug DMA.
- Serialises accesses, inserts the memory's fixed read latency, and returns one response per accepted request.
- Sits between the core datapath and the memory macro.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width (multiple of 8).
- MEM_LATENCY, 1, cycles from mem_en to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_i  in  2  per-requester request; held until gnt_o[n]
- we_i  in  2  per-requester write enable
- addr_i  in  2xADDR_W  per-requester address
- wdata_i  in  2xDATA_W  per-requester write data
- be_i  in  2x(DATA_W/8)  per-requester byte enables
- gnt_o  out  2  one-cycle pulse: request consumed
- rvalid_o  out  2  one-cycle pulse: access complete (read data or write ack)
- rdata_o  out  DATA_W  read data, valid with any rvalid_o bit
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- All outputs are registered. Reset values:
  - gnt_o = 0, rvalid_o = 0, rdata_o = 0
  - mem_en_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, mem_be_o = 0
  - busy_o = 0
  - state = IDLE, last_owner = 1, wait counter = 0
- State machine IDLE -> ACCESS -> WAIT -> RESP -> IDLE:
  - IDLE, cycle t, any req_i bit high: choose owner, latch owner's we/addr/wdata/be, go to ACCESS.
  - ACCESS (t+1): mem_en_o = 1 for exactly one cycle, mem_* carry the latched fields, gnt_o[owner] = 1. Load counter with MEM_LATENCY-1, go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, capture mem_rdata_i (on a read) and go to RESP. mem_rdata_i is sampled at cycle t+1+MEM_LATENCY.
  - RESP (t+2+MEM_LATENCY): rvalid_o[owner] = 1. rdata_o holds the captured data for a read, 0 for a write. Update last_owner = owner, go to IDLE.
- Latency from req to rvalid: MEM_LATENCY+2 cycles. Throughput: one access per MEM_LATENCY+3 cycles.
- Arbitration:
  - Only one req bit high: that requester wins.
  - Both high: the requester != last_owner wins (round-robin).
  - After reset, last_owner = 1, so the core (0) wins the first tie.
- Requests are sampled only in IDLE. Changes to req/addr/wdata while not in IDLE are ignored; the latched values are used.
- A requester dropping req before gnt is legal; the request is withdrawn if the drop happens before IDLE samples it.
- rdata_o holds its value between responses. mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o hold their values outside ACCESS. Only mem_en_o qualifies them.
- Reset mid-operation (any state): the access is aborted. No gnt_o or rvalid_o is issued for it. All outputs take reset values on the next edge. A write already strobed is not undone.
- gnt_o and rvalid_o never both have two bits set. At most one of the two is non-zero in any cycle.
- No address decoding, no misalignment checking; be_i is passed through unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, WAIT, RESP, 2 bits)
  - requester id constants REQ_CORE = 0, REQ_DMA = 1
  - counter width constant LAT_W = 4
- One sub-module, rr_arb2: combinational two-way round-robin chooser. Inputs: req[1:0], last_owner. Output: owner.
- The FSM, counter and registers live in mem_port_arbiter.

Test Plan:
- Single read, MEM_LATENCY=1:
  - Stimulus: core req, we=0, addr=0x0000_0010, memory returns 0xDEAD_BEEF.
  - Response: gnt_o=01 at t+1, mem_en_o=1 at t+1 only, rvalid_o=01 with rdata_o=0xDEAD_BEEF at t+3.
- Single write:
  - Stimulus: DMA writes 0x1234_5678 to 0x0000_0100, be=4'b0011.
  - Response: mem_we_o=1, mem_be_o=0011 with mem_en_o at t+1. rvalid_o=10, rdata_o=0 at t+3.
- Simultaneous requests held continuously after reset:
  - Response: grant order core, DMA, core, DMA. Each rvalid matches its owner's bit.
- MEM_LATENCY=4 read:
  - Response: mem_rdata_i sampled at t+5, rvalid at t+6. busy_o high for t+1..t+6.
- Requests changing while busy:
  - Stimulus: core changes addr from 0x20 to 0x40 during WAIT.
  - Response: mem_addr_o stays 0x20; the new request is served only after return to IDLE.
- Reset mid-access:
  - Stimulus: reset asserted in WAIT.
  - Response: no rvalid_o. All outputs 0 next cycle. A subsequent simultaneous request grants the core first.
